// File: rtl/spi_reg_ctrl_if.sv
// Byte-level SPI core user port, chip-select events and 8-bit register bus,
// bundled for the command sequencer. The master modport is the sequencer's
// view: it drives the MISO holding byte and the bus request side.
`timescale 1ns/1ps
interface spi_reg_ctrl_if #(
  parameter int AW = 16
);
  logic [7:0]    usr_mosi_data;
  logic          usr_mosi_stb;
  logic [7:0]    usr_miso_data;
  logic          usr_miso_ack;
  logic          csn_state;
  logic          csn_fall;
  logic          csn_rise;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_wdata;
  logic [7:0]    bus_rdata;
  logic          bus_we;
  logic          bus_cyc;
  logic          bus_ack;

  modport master (
    input  usr_mosi_data, usr_mosi_stb, usr_miso_ack,
    input  csn_state, csn_fall, csn_rise,
    input  bus_rdata, bus_ack,
    output usr_miso_data, bus_addr, bus_wdata, bus_we, bus_cyc
  );

  modport slave (
    output usr_mosi_data, usr_mosi_stb, usr_miso_ack,
    output csn_state, csn_fall, csn_rise,
    output bus_rdata, bus_ack,
    input  usr_miso_data, bus_addr, bus_wdata, bus_we, bus_cyc
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI command sequencer: decodes CMD/ADDR_H/ADDR_L at the start of each
// chip-select frame, then streams write bytes onto the register bus or
// prefetches read bytes into the core's MISO holding register, with an
// auto-incrementing address. At most one bus cycle is ever outstanding.
`timescale 1ns/1ps
module spi_reg_ctrl #(
  parameter int         AW     = 16,
  parameter logic [7:0] CMD_WR = 8'h02,
  parameter logic [7:0] CMD_RD = 8'h03
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_reg_ctrl_if.master bif,
  output logic           err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_WR_DATA,
    S_RD_DUMMY,
    S_RD_DATA,
    S_IGNORE
  } state_t;

  state_t        r_state;
  logic          r_rd;      // direction of the current frame, 1 = read
  logic [7:0]    r_addr_h;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_wdata;
  logic          r_we;
  logic          r_cyc;
  logic [7:0]    r_miso;
  logic          r_err;

  // Deselected or closing frame: FSM returns to IDLE, in-flight cycle still finishes.
  logic          w_abort;
  logic [15:0]   w_addr_full;
  logic          w_done;

  assign w_abort     = bif.csn_state | bif.csn_rise;
  assign w_addr_full = {r_addr_h, bif.usr_mosi_data};
  assign w_done      = r_cyc & bif.bus_ack;

  assign bif.bus_addr      = r_addr;
  assign bif.bus_wdata     = r_wdata;
  assign bif.bus_we        = r_we;
  assign bif.bus_cyc       = r_cyc;
  assign bif.usr_miso_data = r_miso;
  assign err               = r_err;

  // Frame FSM, bus cycle control, address counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rd     <= 1'b0;
      r_addr_h <= 8'h00;
      r_addr   <= '0;
      r_wdata  <= 8'h00;
      r_we     <= 1'b0;
      r_cyc    <= 1'b0;
      r_miso   <= 8'h00;
      r_err    <= 1'b0;
    end else begin
      // Completion is honoured in any state, including after an abort.
      if (w_done) begin
        r_cyc  <= 1'b0;
        r_addr <= r_addr + AW'(1);
        if (!r_we)
          r_miso <= bif.bus_rdata;
      end

      if (bif.csn_fall)
        r_err <= 1'b0;

      // Launches below require !r_cyc, so they never collide with the
      // completion clear above; a new cycle starts no earlier than the
      // cycle after bus_cyc has dropped.
      if (w_abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bif.usr_mosi_stb) begin
              if (bif.usr_mosi_data == CMD_WR) begin
                r_rd    <= 1'b0;
                r_state <= S_ADDR_H;
              end else if (bif.usr_mosi_data == CMD_RD) begin
                r_rd    <= 1'b1;
                r_state <= S_ADDR_H;
              end else begin
                r_state <= S_IGNORE;
              end
            end
          end

          S_ADDR_H: begin
            if (bif.usr_mosi_stb) begin
              r_addr_h <= bif.usr_mosi_data;
              r_state  <= S_ADDR_L;
            end
          end

          S_ADDR_L: begin
            if (bif.usr_mosi_stb) begin
              // Upper address bits beyond AW are dropped here.
              r_addr  <= w_addr_full[AW-1:0];
              r_state <= r_rd ? S_RD_DUMMY : S_WR_DATA;
            end
          end

          S_WR_DATA: begin
            if (bif.usr_mosi_stb) begin
              if (r_cyc) begin
                // Previous write still pending: drop this byte.
                r_err <= 1'b1;
              end else begin
                r_cyc   <= 1'b1;
                r_we    <= 1'b1;
                r_wdata <= bif.usr_mosi_data;
              end
            end
          end

          S_RD_DUMMY: begin
            // Core has taken the dummy byte; prefetch the first real one.
            if (bif.usr_miso_ack) begin
              if (!r_cyc) begin
                r_cyc <= 1'b1;
                r_we  <= 1'b0;
              end
              r_state <= S_RD_DATA;
            end
          end

          S_RD_DATA: begin
            if (bif.usr_miso_ack) begin
              if (r_cyc) begin
                // Core latched a stale byte; no new read, data left as is.
                r_err <= 1'b1;
              end else begin
                r_cyc <= 1'b1;
                r_we  <= 1'b0;
              end
            end
          end

          S_IGNORE: ;

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: byte-level SPI core model, bus slave with
// programmable ack latency, and hand-computed expectations.
`timescale 1ns/1ps
module tb_spi_reg_ctrl;
  localparam int AW       = 16;
  localparam int BYTE_CLK = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;

  spi_reg_ctrl_if #(.AW(AW)) sif();

  spi_reg_ctrl #(.AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (sif.master),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  logic [7:0]  mem [0:65535];
  logic [23:0] wr_log[$];
  logic [15:0] rd_log[$];
  int          wid_log[$];
  logic [7:0]  miso_cap[$];
  logic [7:0]  tx_q[$];
  int          ack_after = 2;
  int          cnt = 0;

  // Bus slave: ack lands ack_after clk after bus_cyc rises, so a cycle is
  // high for ack_after+1 clk; width is the number of clk bus_cyc was high.
  always @(negedge clk) begin
    if (sif.bus_ack) begin
      sif.bus_ack = 1'b0;
      cnt = 0;
    end else if (sif.bus_cyc) begin
      cnt++;
      if (cnt == ack_after + 1) begin
        sif.bus_ack = 1'b1;
        wid_log.push_back(cnt);
        if (sif.bus_we) begin
          mem[sif.bus_addr] = sif.bus_wdata;
          wr_log.push_back({sif.bus_addr, sif.bus_wdata});
        end else begin
          sif.bus_rdata = mem[sif.bus_addr];
          rd_log.push_back(sif.bus_addr);
        end
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    wr_log.delete(); rd_log.delete(); wid_log.delete(); miso_cap.delete();
  endtask

  task automatic frame_begin();
    sif.csn_state = 1'b0; sif.csn_fall = 1'b1;
    @(negedge clk); sif.csn_fall = 1'b0;
    tick(2);
  endtask

  task automatic frame_end();
    sif.csn_state = 1'b1; sif.csn_rise = 1'b1;
    @(negedge clk); sif.csn_rise = 1'b0;
    tick(2);
  endtask

  // One byte slot: core latches MISO at the start, delivers MOSI at the end.
  task automatic send_byte(input logic [7:0] b);
    miso_cap.push_back(sif.usr_miso_data);
    sif.usr_miso_ack = 1'b1;
    @(negedge clk); sif.usr_miso_ack = 1'b0;
    tick(BYTE_CLK - 2);
    sif.usr_mosi_data = b; sif.usr_mosi_stb = 1'b1;
    @(negedge clk); sif.usr_mosi_stb = 1'b0;
  endtask

  task automatic send_bytes();
    foreach (tx_q[i]) send_byte(tx_q[i]);
  endtask

  task automatic send_frame();
    frame_begin();
    send_bytes();
    frame_end();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sif.bus_cyc && k < 2000) begin
      @(negedge clk); k++;
    end
    tick(2);
    chk("bus_idle", {31'd0, sif.bus_cyc}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    sif.usr_mosi_data = 8'h00; sif.usr_mosi_stb = 1'b0; sif.usr_miso_ack = 1'b0;
    sif.csn_state = 1'b1; sif.csn_fall = 1'b0; sif.csn_rise = 1'b0;
    sif.bus_rdata = 8'h00; sif.bus_ack = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Reset state
    chk("rst_miso",  {24'd0, sif.usr_miso_data}, 32'h00);
    chk("rst_addr",  {16'd0, sif.bus_addr}, 32'h0000);
    chk("rst_wdata", {24'd0, sif.bus_wdata}, 32'h00);
    chk("rst_we",    {31'd0, sif.bus_we}, 0);
    chk("rst_cyc",   {31'd0, sif.bus_cyc}, 0);
    chk("rst_err",   {31'd0, err}, 0);

    // Write burst
    ack_after = 2; clear_logs();
    tx_q = '{8'h02, 8'h12, 8'h34, 8'hAA, 8'hBB, 8'hCC};
    send_frame(); wait_idle();
    chk("wr_n",    wr_log.size(), 3);
    chk("wr0",     wr_log[0], 24'h1234AA);
    chk("wr1",     wr_log[1], 24'h1235BB);
    chk("wr2",     wr_log[2], 24'h1236CC);
    chk("wr_wid0", wid_log[0], 3);
    chk("wr_wid1", wid_log[1], 3);
    chk("wr_wid2", wid_log[2], 3);
    chk("wr_err",  {31'd0, err}, 0);

    // Read burst
    mem[16'h0040] = 8'h11; mem[16'h0041] = 8'h22; mem[16'h0042] = 8'h33; mem[16'h0043] = 8'h44;
    clear_logs();
    tx_q = '{8'h03, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(); wait_idle();
    chk("rd_n",    rd_log.size(), 4);
    chk("rd_a0",   rd_log[0], 16'h0040);
    chk("rd_a1",   rd_log[1], 16'h0041);
    chk("rd_a2",   rd_log[2], 16'h0042);
    chk("rd_a3",   rd_log[3], 16'h0043);
    chk("miso_p1", miso_cap[4], 8'h11);
    chk("miso_p2", miso_cap[5], 8'h22);
    chk("miso_p3", miso_cap[6], 8'h33);
    chk("miso_last", {24'd0, sif.usr_miso_data}, 32'h44);
    chk("rd_err",  {31'd0, err}, 0);

    // Unknown command, then a normal write
    clear_logs();
    tx_q = '{8'h9F, 8'h01, 8'h02, 8'h03};
    send_frame(); wait_idle();
    chk("unk_cyc", wid_log.size(), 0);
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h5A};
    send_frame(); wait_idle();
    chk("unk_wr_n", wr_log.size(), 1);
    chk("unk_wr0",  wr_log[0], 24'h00005A);

    // Address wrap
    clear_logs();
    tx_q = '{8'h02, 8'hFF, 8'hFF, 8'h01, 8'h02};
    send_frame(); wait_idle();
    chk("wrap_n",  wr_log.size(), 2);
    chk("wrap0",   wr_log[0], 24'hFFFF01);
    chk("wrap1",   wr_log[1], 24'h000002);

    // Write overrun
    ack_after = 200; clear_logs();
    tx_q = '{8'h02, 8'h00, 8'h10, 8'hA1, 8'hA2};
    send_frame();
    chk("ovr_err", {31'd0, err}, 1);
    wait_idle();
    chk("ovr_n",   wr_log.size(), 1);
    chk("ovr_wr0", wr_log[0], 24'h0010A1);
    chk("ovr_err_sticky", {31'd0, err}, 1);
    frame_begin();
    chk("ovr_err_clr", {31'd0, err}, 0);
    frame_end();

    // CS abort with a read pending
    ack_after = 40; mem[16'h0100] = 8'h77; clear_logs();
    tx_q = '{8'h03, 8'h01, 8'h00, 8'h00};
    send_frame();
    chk("abort_pend", {31'd0, sif.bus_cyc}, 1);
    wait_idle();
    chk("abort_miso", {24'd0, sif.usr_miso_data}, 32'h77);
    chk("abort_rd_n", rd_log.size(), 1);
    chk("abort_rd_a", rd_log[0], 16'h0100);
    chk("abort_wid",  wid_log[0], 41);
    tick(20);
    chk("abort_nomore", wid_log.size(), 1);

    // Reset mid-cycle with a write pending
    ack_after = 200; clear_logs();
    frame_begin();
    tx_q = '{8'h02, 8'h00, 8'h20, 8'hC3};
    send_bytes();
    tick(3);
    chk("rstm_pend", {31'd0, sif.bus_cyc}, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rstm_cyc",   {31'd0, sif.bus_cyc}, 0);
    chk("rstm_miso",  {24'd0, sif.usr_miso_data}, 32'h00);
    chk("rstm_addr",  {16'd0, sif.bus_addr}, 32'h0000);
    chk("rstm_we",    {31'd0, sif.bus_we}, 0);
    chk("rstm_wdata", {24'd0, sif.bus_wdata}, 32'h00);
    @(negedge clk); rst_n = 1'b1;
    frame_end();
    tick(5);
    chk("rstm_nowr", wr_log.size(), 0);

    // Normal operation after reset
    ack_after = 2; clear_logs();
    tx_q = '{8'h02, 8'hAB, 8'hCD, 8'hEE};
    send_frame(); wait_idle();
    chk("post_n",   wr_log.size(), 1);
    chk("post_wr0", wr_log[0], 24'hABCDEE);
    chk("post_err", {31'd0, err}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
